// File: rtl/key_selection.sv
// Anubis key-selection stage phi = tau . omega . gamma, serialised one key row per cycle.
// Each evolved 128-bit key is turned into a round key tagged with its round number.
module key_selection #(
    parameter int unsigned ROW_CYCLES = 4,
    parameter int unsigned ROUNDS     = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_key,
    input  logic [127:0] evolutioned_key,
    input  logic [3:0]   round_num,
    output logic         busy,
    output logic         round_key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_key_num,
    output logic         range_err
);

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        DONE
    } state_t;

    // Anubis S-box (involution), entry 0 first.
    localparam logic [0:255][7:0] SBOX = {
        128'ha7d3e671d0ac4d793ac991fc1e4754bd,
        128'h8ca57afb63b8ddd4e5b3c5bea9880ca2,
        128'h39df29da2ba8cb4c4b22aa244170a6f9,
        128'h5ae2b0367de433ff6020088b5eab7f78,
        128'h7c2c57d2dc6d7e0d5394c32827065fad,
        128'h675c55480e52ea425b5d305851593c4e,
        128'h388a7214e7c6de508e92d17793459ace,
        128'h2d0362b6b9bf966b3f0712ae4034463e,
        128'hdbcfecccc1a1c0d61df4613b10d868a0,
        128'hb10a696c49fa76c49e9b6e99c2b798bc,
        128'h8f851fb4f8112e00251c2a3d054f7bb2,
        128'h3290af19a3f7739d1574eeca9f0f1b75,
        128'h86849c4a971a65f6ed09bb2683eb6f81,
        128'h046a430117e187f58de3238044166621,
        128'hfed531d935180264f2f156cd82c8baf0,
        128'hefe9e8fd89d7c7b5a42f95130bf3e037
    };

    // VPOW[k][i] = x_k^i for x = (01,02,06,08) over GF(2^8)/0x11D.
    localparam logic [0:3][0:3][7:0] VPOW = {
        32'h01010101,
        32'h01020408,
        32'h01061478,
        32'h0108403a
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned n = 0; n < 8; n++) begin
            if (b[n]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1d : 8'h00);
        end
        return p;
    endfunction

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   num_q, num_d;
    logic [127:0] acc_q, acc_d;
    logic [1:0]   row_q, row_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rkn_q, rkn_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;

    logic [31:0]  row_word;
    logic [7:0]   sub;
    logic [127:0] contrib;

    // key_q is shifted up one row per PROC cycle, so the current row is always on top.
    // The accumulator is kept already transposed: byte 4j+i holds W[i][j].
    always_comb begin
        contrib  = '0;
        sub      = '0;
        row_word = key_q[127:96];
        for (int unsigned j = 0; j < 4; j++) begin
            sub = SBOX[row_word[31 - 8*j -: 8]];
            for (int unsigned i = 0; i < 4; i++) begin
                contrib[127 - 8*(4*j + i) -: 8] = gf_mul(VPOW[row_q][i[1:0]], sub);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        num_d   = num_q;
        acc_d   = acc_q;
        row_d   = row_q;
        rk_d    = rk_q;
        rkn_d   = rkn_q;
        valid_d = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (load_key) begin
                    key_d   = evolutioned_key;
                    num_d   = round_num;
                    acc_d   = '0;
                    row_d   = '0;
                    state_d = PROC;
                    if ({28'b0, round_num} > ROUNDS) err_d = 1'b1;
                end
            end
            PROC: begin
                acc_d = acc_q ^ contrib;
                key_d = {key_q[95:0], 32'b0};
                row_d = row_q + 2'd1;
                if (row_q == 2'(ROW_CYCLES - 1)) state_d = DONE;
            end
            DONE: begin
                rk_d    = acc_q;
                rkn_d   = num_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            num_q   <= '0;
            acc_q   <= '0;
            row_q   <= '0;
            rk_q    <= '0;
            rkn_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            num_q   <= num_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            rk_q    <= rk_d;
            rkn_q   <= rkn_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign round_key_valid = valid_q;
    assign round_key       = rk_q;
    assign round_key_num   = rkn_q;
    assign range_err       = err_q;

endmodule
